// File: rtl/tetris_board_ctrl.sv
// Tetris playfield owner: holds the 20x10 grid and score, sequences the
// start/play/game-over screens and scans for full rows after each piece lock.
module tetris_board_ctrl #(
  parameter int ROWS      = 20,
  parameter int COLS      = 10,
  parameter int SCORE_MAX = 999
) (
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic                             start_key,
  input  logic                             wr_valid,
  input  logic [4:0]                       wr_row,
  input  logic [3:0]                       wr_col,
  input  logic [2:0]                       wr_color,
  input  logic                             commit,
  input  logic                             spawn_blocked,
  output logic [ROWS-1:0][COLS-1:0][2:0]   grid,
  output logic [9:0]                       score,
  output logic                             startscreen,
  output logic                             game_over,
  output logic                             busy,
  output logic                             clear_done
);

  localparam logic [4:0] ROW_LIM   = 5'(ROWS);
  localparam logic [3:0] COL_LIM   = 4'(COLS);
  localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
  localparam logic [9:0] SCORE_SAT = 10'(SCORE_MAX);

  typedef enum logic [2:0] {START, PLAY, SCAN, DONE, OVER} state_t;

  state_t     state;
  logic [4:0] scan_row;
  logic       row_full;
  logic       write_hit;

  assign write_hit = wr_valid && (wr_row < ROW_LIM) && (wr_col < COL_LIM);

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (grid[scan_row][c] == 3'd0) row_full = 1'b0;
    end
  end

  // A full row is removed by pulling every row above it down one place;
  // the scan pointer stays put so the row that dropped in is checked next.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= START;
      grid        <= '0;
      score       <= '0;
      startscreen <= 1'b1;
      game_over   <= 1'b0;
      busy        <= 1'b0;
      clear_done  <= 1'b0;
      scan_row    <= LAST_ROW;
    end else begin
      clear_done <= 1'b0;
      case (state)
        START: begin
          if (start_key) begin
            state       <= PLAY;
            startscreen <= 1'b0;
          end
        end
        PLAY: begin
          if (write_hit) grid[wr_row][wr_col] <= wr_color;
          if (spawn_blocked) begin
            state     <= OVER;
            game_over <= 1'b1;
          end else if (commit) begin
            state    <= SCAN;
            busy     <= 1'b1;
            scan_row <= LAST_ROW;
          end
        end
        SCAN: begin
          if (row_full) begin
            grid[0] <= '0;
            for (int i = 1; i < ROWS; i++) begin
              if (5'(i) <= scan_row) grid[i] <= grid[i-1];
            end
            if (score < SCORE_SAT) score <= score + 10'd1;
          end else if (scan_row == 5'd0) begin
            state      <= DONE;
            clear_done <= 1'b1;
          end else begin
            scan_row <= scan_row - 5'd1;
          end
        end
        DONE: begin
          state <= PLAY;
          busy  <= 1'b0;
        end
        OVER: begin
          if (start_key) begin
            state       <= START;
            game_over   <= 1'b0;
            startscreen <= 1'b1;
            grid        <= '0;
            score       <= '0;
          end
        end
        default: state <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_board_ctrl.sv
// Scoreboard bench for tetris_board_ctrl: a row-compaction model predicts the
// grid, score and clear_done latency of every scan.
module tb_tetris_board_ctrl;

  localparam int ROWS      = 20;
  localparam int COLS      = 10;
  localparam int SCORE_MAX = 999;

  typedef logic [ROWS-1:0][COLS-1:0][2:0] grid_t;
  typedef logic [639:0] wide_t;
  typedef struct packed {
    logic [31:0] latency;
    logic [9:0]  score;
    grid_t       grid;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       start_key, wr_valid, commit, spawn_blocked;
  logic [4:0] wr_row;
  logic [3:0] wr_col;
  logic [2:0] wr_color;
  grid_t      grid;
  logic [9:0] score;
  logic       startscreen, game_over, busy, clear_done;

  exp_t  sb[$];
  grid_t model_grid;
  int    model_score;
  int    n_compared   = 0;
  int    n_mismatched = 0;

  tetris_board_ctrl #(.ROWS(ROWS), .COLS(COLS), .SCORE_MAX(SCORE_MAX)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start_key(start_key), .wr_valid(wr_valid),
    .wr_row(wr_row), .wr_col(wr_col), .wr_color(wr_color), .commit(commit),
    .spawn_blocked(spawn_blocked), .grid(grid), .score(score),
    .startscreen(startscreen), .game_over(game_over), .busy(busy),
    .clear_done(clear_done)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input wide_t actual, input wide_t expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] row, input logic [3:0] col,
                               input logic [2:0] color, input logic cm, input logic sk,
                               input logic sp);
    wr_valid = v; wr_row = row; wr_col = col; wr_color = color;
    commit = cm; start_key = sk; spawn_blocked = sp;
    tick;
    wr_valid = 1'b0; commit = 1'b0; start_key = 1'b0; spawn_blocked = 1'b0;
  endtask

  task automatic write_cell(input int row, input int col, input int color);
    if (row < ROWS && col < COLS) model_grid[row][col] = 3'(color);
    applyStimulus(1'b1, 5'(row), 4'(col), 3'(color), 1'b0, 1'b0, 1'b0);
  endtask

  // Reference: drop every full row and let the rest settle to the bottom.
  task automatic model_clear(output int k);
    grid_t g;
    int    dst;
    bit    full;
    g = '0; dst = ROWS - 1; k = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (model_grid[r][c] == 3'd0) full = 1'b0;
      if (full) k++;
      else begin
        g[dst] = model_grid[r];
        dst--;
      end
    end
    model_grid  = g;
    model_score = (model_score + k > SCORE_MAX) ? SCORE_MAX : model_score + k;
  endtask

  task automatic run_scan(input string tag, input bit with_write, input int row, input int col,
                          input int color, input bit mid_write);
    exp_t e;
    int   k, cyc;
    bit   busy_ok;
    if (with_write && row < ROWS && col < COLS) model_grid[row][col] = 3'(color);
    model_clear(k);
    e.latency = 32'(ROWS + k + 1);
    e.score   = 10'(model_score);
    e.grid    = model_grid;
    sb.push_back(e);
    applyStimulus(with_write, 5'(row), 4'(col), 3'(color), 1'b1, 1'b0, 1'b0);
    cyc = 1; busy_ok = 1'b1;
    while (!clear_done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (mid_write && cyc == 3) begin
        wr_valid = 1'b1; wr_row = 5'd0; wr_col = 4'd0; wr_color = 3'd6;
      end
      tick;
      wr_valid = 1'b0;
      cyc++;
    end
    if (!busy) busy_ok = 1'b0;
    e = sb.pop_front();
    checkOutput({tag, "_latency"}, wide_t'(cyc), wide_t'(e.latency));
    checkOutput({tag, "_score"}, wide_t'(score), wide_t'(e.score));
    checkOutput({tag, "_grid"}, wide_t'(grid), wide_t'(e.grid));
    checkOutput({tag, "_busy"}, wide_t'(busy_ok), wide_t'(1));
    tick;
    checkOutput({tag, "_resume"}, wide_t'({busy, clear_done}), wide_t'(0));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    Reset_n = 1'b1;
    wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_color = '0;
    commit = 1'b0; start_key = 1'b0; spawn_blocked = 1'b0;
    model_grid = '0; model_score = 0;

    #2 Reset_n = 1'b0;
    tick; tick;
    checkOutput("rst_flags", wide_t'({startscreen, game_over, busy, clear_done}), wide_t'(4'b1000));
    checkOutput("rst_score", wide_t'(score), wide_t'(0));
    checkOutput("rst_grid", wide_t'(grid), wide_t'(0));
    Reset_n = 1'b1;
    tick;
    checkOutput("start_wait", wide_t'(startscreen), wide_t'(1));
    applyStimulus(1'b0, 5'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("start_play", wide_t'(startscreen), wide_t'(0));

    write_cell(19, 3, 5);
    checkOutput("write_latency", wide_t'(grid[19][3]), wide_t'(5));
    write_cell(20, 0, 7);
    write_cell(0, 10, 7);
    checkOutput("oob_ignored", wide_t'(grid), wide_t'(model_grid));
    run_scan("noclear", 1'b0, 0, 0, 0, 1'b0);

    for (int c = 0; c < 9; c++) write_cell(19, c, (c % 7) + 1);
    write_cell(18, 0, 2);
    run_scan("single", 1'b1, 19, 9, (9 % 7) + 1, 1'b0);

    for (int r = 16; r < 20; r++)
      for (int c = 0; c < COLS; c++) write_cell(r, c, ((r + c) % 7) + 1);
    write_cell(15, 4, 3);
    run_scan("tetris", 1'b0, 0, 0, 0, 1'b1);

    for (int c = 0; c < COLS; c++) write_cell(0, c, 7);
    run_scan("row0", 1'b0, 0, 0, 0, 1'b0);

    write_cell(10, 2, 7);
    applyStimulus(1'b0, 5'd0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("over_flags", wide_t'({game_over, busy, startscreen}), wide_t'(3'b100));
    applyStimulus(1'b1, 5'd5, 4'd5, 3'd3, 1'b1, 1'b0, 1'b0);
    tick; tick;
    checkOutput("over_frozen_grid", wide_t'(grid), wide_t'(model_grid));
    checkOutput("over_frozen_score", wide_t'(score), wide_t'(model_score));
    checkOutput("over_no_scan", wide_t'({busy, clear_done}), wide_t'(0));
    applyStimulus(1'b0, 5'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    model_grid = '0; model_score = 0;
    checkOutput("restart_flags", wide_t'({startscreen, game_over}), wide_t'(2'b10));
    checkOutput("restart_grid", wide_t'(grid), wide_t'(0));
    checkOutput("restart_score", wide_t'(score), wide_t'(0));
    applyStimulus(1'b0, 5'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 250; n++) begin
      k = (n == 249) ? 3 : 4;
      for (int r = ROWS - k; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) write_cell(r, c, 1);
      run_scan("preload", 1'b0, 0, 0, 0, 1'b0);
    end
    checkOutput("preload_999", wide_t'(score), wide_t'(999));
    for (int c = 0; c < COLS; c++) write_cell(19, c, 2);
    write_cell(18, 5, 4);
    run_scan("saturate", 1'b0, 0, 0, 0, 1'b0);

    for (int c = 0; c < COLS; c++) write_cell(19, c, 6);
    applyStimulus(1'b0, 5'd0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    tick; tick; tick; tick;
    checkOutput("midscan_busy", wide_t'(busy), wide_t'(1));
    Reset_n = 1'b0;
    #1;
    checkOutput("midrst_flags", wide_t'({startscreen, game_over, busy, clear_done}), wide_t'(4'b1000));
    checkOutput("midrst_score", wide_t'(score), wide_t'(0));
    checkOutput("midrst_grid", wide_t'(grid), wide_t'(0));
    tick;
    Reset_n = 1'b1;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
